// File: rtl/touch_detector_if.sv
// Pad-side bundle for touch_detector: the sensor sample handshake plus the
// touch decision returned to game logic.
interface touch_detector_if;
  logic [31:0] final_count;
  logic        sample_strobe;
  logic        recal;
  logic        touched;
  logic        hit_pulse;
  logic [31:0] baseline;
  logic        calibrated;

  // Producer side: drives samples and recal, observes the decision.
  modport master (
    output final_count, sample_strobe, recal,
    input  touched, hit_pulse, baseline, calibrated
  );

  // Detector side.
  modport slave (
    input  final_count, sample_strobe, recal,
    output touched, hit_pulse, baseline, calibrated
  );
endinterface

// File: rtl/touch_detector.sv
// touch_detector: per-pad baseline calibration, hysteretic debounced touch
// decision with a one-cycle hit strobe, and slow baseline drift tracking
// while the pad is idle.
module touch_detector #(
  parameter int CAL_LOG2    = 3,
  parameter int THRESH_ON   = 200,
  parameter int THRESH_OFF  = 100,
  parameter int DEBOUNCE    = 3,
  parameter int DRIFT_SHIFT = 4
) (
  input logic             clock,
  input logic             reset_n,
  touch_detector_if.slave pad
);

  localparam int ACC_W = 32 + CAL_LOG2;

  typedef enum logic [1:0] {
    ST_CAL     = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PRESSED = 2'd2
  } state_e;

  state_e               state_q;
  logic [ACC_W-1:0]     acc_q;
  logic [CAL_LOG2-1:0]  cnt_q;
  logic [3:0]           deb_q;
  logic                 touched_q;
  logic                 hit_q;
  logic [31:0]          base_q;
  logic                 cal_q;

  logic                 valid_d;
  logic [ACC_W-1:0]     acc_sum_d;
  logic [32:0]          on_lvl_d;
  logic [32:0]          off_lvl_d;
  logic [32:0]          sample_d;
  logic signed [32:0]   diff_d;
  logic signed [32:0]   step_d;
  logic [31:0]          drift_base_d;
  logic [3:0]           deb_inc_d;
  logic                 deb_done_d;

  // Sample qualification, thresholds (33 bits so no wrap near 2^32) and the
  // drift step, all derived from the current sample and baseline.
  always_comb begin
    valid_d      = pad.sample_strobe && (pad.final_count != 32'd0);
    acc_sum_d    = acc_q + ACC_W'(pad.final_count);
    sample_d     = {1'b0, pad.final_count};
    on_lvl_d     = {1'b0, base_q} + 33'(THRESH_ON);
    off_lvl_d    = {1'b0, base_q} + 33'(THRESH_OFF);
    diff_d       = $signed(sample_d) - $signed({1'b0, base_q});
    step_d       = diff_d >>> DRIFT_SHIFT;
    drift_base_d = base_q + step_d[31:0];
    deb_inc_d    = deb_q + 4'd1;
    deb_done_d   = (deb_inc_d == 4'(DEBOUNCE));
  end

  // Main FSM: recal has priority, zero counts are ignored, hit is a pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CAL;
      acc_q     <= '0;
      cnt_q     <= '0;
      deb_q     <= '0;
      touched_q <= 1'b0;
      hit_q     <= 1'b0;
      base_q    <= '0;
      cal_q     <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      if (pad.recal) begin
        // Baseline deliberately holds until the new calibration completes.
        state_q   <= ST_CAL;
        acc_q     <= '0;
        cnt_q     <= '0;
        deb_q     <= '0;
        touched_q <= 1'b0;
        cal_q     <= 1'b0;
      end else if (valid_d) begin
        unique case (state_q)
          ST_CAL: begin
            if (cnt_q == {CAL_LOG2{1'b1}}) begin
              base_q  <= 32'(acc_sum_d >> CAL_LOG2);
              cal_q   <= 1'b1;
              deb_q   <= '0;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              acc_q <= acc_sum_d;
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_IDLE: begin
            if (sample_d > on_lvl_d) begin
              if (deb_done_d) begin
                touched_q <= 1'b1;
                hit_q     <= 1'b1;
                deb_q     <= '0;
                state_q   <= ST_PRESSED;
              end else begin
                deb_q <= deb_inc_d;
              end
            end else begin
              deb_q  <= '0;
              base_q <= drift_base_d;
            end
          end
          ST_PRESSED: begin
            if (sample_d < off_lvl_d) begin
              if (deb_done_d) begin
                touched_q <= 1'b0;
                deb_q     <= '0;
                state_q   <= ST_IDLE;
              end else begin
                deb_q <= deb_inc_d;
              end
            end else begin
              deb_q <= '0;
            end
          end
          default: state_q <= ST_CAL;
        endcase
      end
    end
  end

  assign pad.touched    = touched_q;
  assign pad.hit_pulse  = hit_q;
  assign pad.baseline   = base_q;
  assign pad.calibrated = cal_q;

endmodule

// File: tb/tb_touch_detector.sv
// Bench for touch_detector: directed plan scenarios with literal checks plus
// randomized stimulus, all compared every cycle against a behavioural model.
module tb_touch_detector;
  localparam int CAL_N      = 8;
  localparam int T_ON       = 200;
  localparam int T_OFF      = 100;
  localparam int DEB        = 3;
  localparam int DSHIFT     = 4;
  localparam longint MASK32 = 64'hFFFF_FFFF;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  touch_detector_if pad_if ();

  touch_detector #(
    .CAL_LOG2(3), .THRESH_ON(T_ON), .THRESH_OFF(T_OFF),
    .DEBOUNCE(DEB), .DRIFT_SHIFT(DSHIFT)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .pad    (pad_if)
  );

  always #5 clock = ~clock;

  // Model state: mode 0=calibrating, 1=untouched, 2=pressed.
  int     m_mode;
  longint m_sum;
  int     m_n;
  int     m_deb;
  longint m_base;
  bit     m_touch, m_hit, m_cal;

  always @(posedge clock or negedge reset_n) begin
    longint s;
    if (!reset_n) begin
      m_mode = 0; m_sum = 0; m_n = 0; m_deb = 0;
      m_base = 0; m_touch = 0; m_hit = 0; m_cal = 0;
    end else begin
      s = longint'(pad_if.final_count);
      m_hit = 0;
      if (pad_if.recal) begin
        m_mode = 0; m_sum = 0; m_n = 0; m_deb = 0; m_touch = 0; m_cal = 0;
      end else if (pad_if.sample_strobe && s != 0) begin
        if (m_mode == 0) begin
          m_sum += s;
          m_n++;
          if (m_n == CAL_N) begin
            m_base = m_sum / CAL_N;
            m_cal = 1; m_deb = 0; m_sum = 0; m_n = 0; m_mode = 1;
          end
        end else if (m_mode == 1) begin
          if (s > m_base + T_ON) begin
            m_deb++;
            if (m_deb == DEB) begin
              m_touch = 1; m_hit = 1; m_deb = 0; m_mode = 2;
            end
          end else begin
            m_deb = 0;
            m_base = (m_base + ((s - m_base) >>> DSHIFT)) & MASK32;
          end
        end else begin
          if (s < m_base + T_OFF) begin
            m_deb++;
            if (m_deb == DEB) begin
              m_touch = 0; m_deb = 0; m_mode = 1;
            end
          end else begin
            m_deb = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (reset_n) begin
      chk("touched", pad_if.touched, m_touch);
      chk("hit_pulse", pad_if.hit_pulse, m_hit);
      chk("baseline", pad_if.baseline, m_base);
      chk("calibrated", pad_if.calibrated, m_cal);
    end
  end

  // One cycle with the given inputs; returns #1 after the sampling edge.
  task automatic cyc(input bit stb, input logic [31:0] cnt, input bit rc);
    pad_if.sample_strobe = stb;
    pad_if.final_count   = cnt;
    pad_if.recal         = rc;
    @(posedge clock);
    #1;
    pad_if.sample_strobe = 1'b0;
    pad_if.recal         = 1'b0;
  endtask

  task automatic strobes(input logic [31:0] cnt, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, cnt, 1'b0);
      cyc(1'b0, 32'd0, 1'b0);
    end
  endtask

  initial begin
    pad_if.sample_strobe = 1'b0;
    pad_if.final_count   = 32'd0;
    pad_if.recal         = 1'b0;
    #12;
    chk("reset_baseline", pad_if.baseline, 0);
    chk("reset_cal", pad_if.calibrated, 0);
    chk("reset_touched", pad_if.touched, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Calibration: 8 x 1000.
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 32'd1000, 1'b0);
      chk("cal_pending", pad_if.calibrated, 0);
    end
    cyc(1'b1, 32'd1000, 1'b0);
    chk("cal_done", pad_if.calibrated, 1);
    chk("cal_base", pad_if.baseline, 1000);
    chk("cal_touch", pad_if.touched, 0);

    // Interrupted qualifying run does not touch.
    strobes(32'd1250, 2);
    strobes(32'd1000, 1);
    strobes(32'd1250, 1);
    chk("interrupt_touch", pad_if.touched, 0);
    strobes(32'd1000, 1);   // clears the partial debounce

    // Drift.
    cyc(1'b1, 32'd1050, 1'b0);
    chk("drift_up", pad_if.baseline, 1003);
    cyc(1'b1, 32'd900, 1'b0);
    chk("drift_down", pad_if.baseline, 996);
    cyc(1'b1, 32'd0, 1'b0);
    chk("zero_ignored", pad_if.baseline, 996);

    // Touch: 3 qualifying samples.
    strobes(32'd1250, 2);
    chk("touch_early", pad_if.touched, 0);
    cyc(1'b1, 32'd1250, 1'b0);
    chk("touch_set", pad_if.touched, 1);
    chk("hit_set", pad_if.hit_pulse, 1);
    cyc(1'b0, 32'd0, 1'b0);
    chk("hit_clear", pad_if.hit_pulse, 0);

    // Hysteresis band holds, then release.
    strobes(32'd1150, 5);
    chk("hyst_hold", pad_if.touched, 1);
    strobes(32'd1050, 2);
    chk("release_early", pad_if.touched, 1);
    cyc(1'b1, 32'd1050, 1'b0);
    chk("release", pad_if.touched, 0);
    chk("release_nohit", pad_if.hit_pulse, 0);
    chk("press_no_drift", pad_if.baseline, 996);

    // Recal mid-press with a coincident strobe.
    strobes(32'd1250, 3);
    chk("repress", pad_if.touched, 1);
    cyc(1'b1, 32'd1250, 1'b1);
    chk("recal_touch", pad_if.touched, 0);
    chk("recal_cal", pad_if.calibrated, 0);
    chk("recal_hit", pad_if.hit_pulse, 0);
    chk("recal_base_hold", pad_if.baseline, 996);
    strobes(32'd2000, 8);
    chk("recal_base", pad_if.baseline, 2000);

    // Async reset mid-calibration.
    cyc(1'b0, 32'd0, 1'b1);
    strobes(32'd3000, 4);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_base", pad_if.baseline, 0);
    chk("areset_cal", pad_if.calibrated, 0);
    chk("areset_touch", pad_if.touched, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Calibration near the top of the range; thresholds must not wrap.
    strobes(32'hFFFF_FF00, 8);
    chk("high_base", pad_if.baseline, 64'hFFFF_FF00);
    strobes(32'hFFFF_FFFF, 3);
    chk("high_touch", pad_if.touched, 1);

    // Randomized phase.
    cyc(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      longint c;
      bit stb, rc;
      c = m_base + longint'($urandom_range(0, 500)) - 200;
      if (m_mode == 0) c = 800 + longint'($urandom_range(0, 400));
      if (c < 0 || $urandom_range(0, 19) == 0) c = 0;
      stb = ($urandom_range(0, 2) == 0);
      rc  = ($urandom_range(0, 299) == 0);
      cyc(stb, 32'(c), rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule

// File: doc/touch_detector.md
Name: touch_detector

Overview:
- Consumes the raw count from capacitive_sensor and turns it into a clean per-pad touch decision for the game logic.
- Flow: calibrates a per-pad baseline, applies on/off thresholds with hysteresis and debounce, and slowly tracks baseline drift while the pad is untouched.
- Outputs: a level (touched) and a one-cycle hit strobe per new touch.
- Instantiation: one instance per mole pad, placed directly after its capacitive_sensor.

Parameters:
- CAL_LOG2, 3: calibration averages 2^CAL_LOG2 valid samples (range 1..8).
- THRESH_ON, 200: touch-asserting margin above baseline, in counts.
- THRESH_OFF, 100: release margin above baseline, in counts. Must satisfy THRESH_OFF < THRESH_ON.
- DEBOUNCE, 3: consecutive qualifying samples needed to change touch state (range 1..15).
- DRIFT_SHIFT, 4: baseline tracking gain is 2^-DRIFT_SHIFT.

Ports:
- clock, input, 1: system clock. All state changes on the rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- final_count, input, 32: latched measurement from capacitive_sensor.
- sample_strobe, input, 1: one-cycle pulse, high when final_count holds a fresh measurement.
- recal, input, 1: synchronous request to discard the baseline and recalibrate.
- touched, output, 1: debounced touch level.
- hit_pulse, output, 1: high for exactly one cycle on each 0->1 transition of touched.
- baseline, output, 32: current baseline estimate.
- calibrated, output, 1: high once a baseline exists.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=CAL; touched=0, hit_pulse=0, baseline=0, calibrated=0.
  - accumulator, calibration sample counter and debounce counter all 0.
- Valid sample: a cycle with sample_strobe=1 and final_count!=0. Zero counts are ignored in every state; nothing changes.
- Latency: each valid sample is evaluated on the edge where sample_strobe is seen. Outputs reflect it from that edge.
- hit_pulse defaults to 0 on every cycle in which it is not explicitly set.
- CAL state:
  - Each valid sample adds to a (32+CAL_LOG2)-bit accumulator.
  - On the 2^CAL_LOG2-th sample: baseline = accumulator >> CAL_LOG2 (truncate), calibrated=1, debounce=0, next state IDLE.
- Thresholds: on_lvl = baseline+THRESH_ON and off_lvl = baseline+THRESH_OFF. Both are computed and compared in 33 bits, so there is no wrap near 2^32.
- IDLE state (touched=0):
  - If sample > on_lvl: debounce += 1. When debounce reaches DEBOUNCE: touched=1, hit_pulse=1, debounce=0, next state PRESSED. Baseline is not updated on qualifying samples.
  - Otherwise: debounce=0 and drift update baseline = baseline + ((sample - baseline) >>> DRIFT_SHIFT).
  - Drift arithmetic: the difference is a 33-bit signed value; the shift is arithmetic (rounds toward -inf); the result is truncated to 32 bits.
- PRESSED state (touched=1):
  - If sample < off_lvl: debounce += 1. When debounce reaches DEBOUNCE: touched=0, debounce=0, next state IDLE.
  - Otherwise: debounce=0.
  - No drift while pressed.
- Hysteresis: samples between off_lvl and on_lvl keep the current state and clear debounce.
- recal=1, any state:
  - Next edge: state=CAL; touched=0, calibrated=0; accumulator, sample counter and debounce cleared; baseline holds its old value until calibration completes.
  - No hit_pulse is generated.
  - recal takes priority over a simultaneous sample_strobe; that sample is discarded.
- sample_strobe held high for several cycles: each high cycle counts as a separate sample. The producer guarantees one-cycle pulses.

Test Plan:
- Calibration: reset, then 8 strobes with count 1000 -> calibrated=1 and baseline=1000 on the 8th strobe edge; touched=0, hit_pulse never 1.
- Touch: calibrated at 1000, strobes 1250,1250,1250 -> touched=1 and a single-cycle hit_pulse on the 3rd edge. Sequence 1250,1250,1000,1250 -> touched stays 0.
- Release/hysteresis: pressed, strobes 1150 x5 -> touched stays 1. Then 1050 x3 -> touched=0 on the 3rd; no hit_pulse.
- Drift: baseline 1000 in IDLE, strobe 1050 -> baseline 1003. Strobe 900 -> baseline 996 (-103>>>4 = -7). Zero-count strobe -> no change.
- Recal mid-press: touched=1, recal pulse coincident with strobe 1250 -> touched=0, calibrated=0, no hit_pulse. Then 8 strobes of 2000 -> baseline=2000.
- Async reset / overflow: reset_n low mid-CAL between edges -> all outputs 0 immediately. Calibrate at 0xFFFFFF00, then strobes 0xFFFFFFFF x3 -> touched=1 (no threshold wrap).
